sub_unit_request_issuer: RTL and testbench

//  Initiator side of memory_sub_unit_interface: accepts load/store/AMO requests from the LSU

---
 rtl/cva5_types.sv | 28 ++
 rtl/memory_sub_unit_interface.sv | 30 +++
 rtl/cva5_fifo.sv | 68 ++++++
 rtl/sub_unit_request_issuer.sv | 187 ++++++++++++++++++
 tb/tb_sub_unit_request_issuer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cva5_types.sv
// ---------------------------------------------------------------------------
// cva5_types
//   Shared types for the LSU sub-unit issue path.
//   - ISSUE_ID_W         : width of the request/response tag carried through
//                          the outstanding-load FIFO
//   - load_fn3_t         : funct3 encodings of the load/store width field
//   - issue_fifo_entry_t : what is remembered about each outstanding load
//                          so its data can be aligned and extended on return
// ---------------------------------------------------------------------------
package cva5_types;

  localparam int ISSUE_ID_W = 3;

  typedef enum logic [2:0] {
    FN3_LB  = 3'd0,
    FN3_LH  = 3'd1,
    FN3_LW  = 3'd2,
    FN3_LBU = 3'd4,
    FN3_LHU = 3'd5
  } load_fn3_t;

  typedef struct packed {
    logic [ISSUE_ID_W-1:0] id;
    logic [1:0]            byte_off;
    logic [2:0]            fn3;
  } issue_fifo_entry_t;

endpackage

// File: rtl/memory_sub_unit_interface.sv
// ---------------------------------------------------------------------------
// memory_sub_unit_interface
//   Handshake between the LSU issue logic (initiator) and one memory
//   sub-unit such as local memory or a bus bridge (responder).
//   initiator drives : new_request, addr, re, we, be, data_in
//   responder drives : ready, data_out, data_valid
// ---------------------------------------------------------------------------
interface memory_sub_unit_interface;

  logic        new_request;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [3:0]  be;
  logic [31:0] data_in;
  logic        ready;
  logic [31:0] data_out;
  logic        data_valid;

  modport initiator (
    output new_request, addr, re, we, be, data_in,
    input  ready, data_out, data_valid
  );

  modport responder (
    input  new_request, addr, re, we, be, data_in,
    output ready, data_out, data_valid
  );

endinterface

// File: rtl/cva5_fifo.sv
// ---------------------------------------------------------------------------
// cva5_fifo
//   Small synchronous FIFO with a combinational head. DEPTH must be a power
//   of two so the read/write pointers wrap naturally.
//   Ports:
//     clk, rst (sync, active-high)
//     push, data_in   : write one entry (ignored when full)
//     pop             : drop the head entry (ignored when empty)
//     data_out        : current head entry
//     empty, full     : occupancy flags
//   Push and pop in the same cycle leave the occupancy unchanged while both
//   pointers advance.
// ---------------------------------------------------------------------------
module cva5_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push_en;
  logic              pop_en;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign data_out = mem[rd_ptr];

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push_en)
      mem[wr_ptr] <= data_in;
  end

  // Pointer and occupancy bookkeeping. The occupancy only moves when exactly
  // one of push/pop is effective, so simultaneous push+pop holds it steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_en && !pop_en)
        count <= count + 1'b1;
      else if (pop_en && !push_en)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sub_unit_request_issuer.sv
// ---------------------------------------------------------------------------
// sub_unit_request_issuer
//   Initiator side of memory_sub_unit_interface. Accepts load/store/AMO
//   requests from the LSU issue stage, drives a single memory sub-unit,
//   tracks outstanding loads in order and returns aligned, extended load
//   data tagged with the request ID. Misaligned requests are rejected.
//   Ports:
//     clk, rst                 clock, sync active-high reset
//     req_valid / req_ready    request handshake
//     req_addr, req_store, req_fn3, req_data, req_amo_rmw, req_id
//                              request fields
//     unit                     memory_sub_unit_interface initiator modport
//     amo_is_rmw               qualifies unit.new_request as an AMO RMW
//     rsp_valid/rsp_data/rsp_id  one-cycle load/AMO result
//     err_valid/err_id         one-cycle misaligned-request rejection
//     proto_err                sticky: data_valid with nothing outstanding
//   ID_W must equal cva5_types::ISSUE_ID_W since the FIFO entry type is
//   shared through the package.
// ---------------------------------------------------------------------------
module sub_unit_request_issuer
  import cva5_types::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = ISSUE_ID_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    req_store,
  input  logic [2:0]              req_fn3,
  input  logic [31:0]             req_data,
  input  logic                    req_amo_rmw,
  input  logic [ID_W-1:0]         req_id,
  memory_sub_unit_interface.initiator unit,
  output logic                    amo_is_rmw,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    err_valid,
  output logic [ID_W-1:0]         err_id,
  output logic                    proto_err
);

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;

  access_size_t      acc_size;
  logic              misaligned;
  logic              accept;
  logic              issue;
  logic              expects_data;
  logic [3:0]        be_mask;
  logic [31:0]       store_data;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  issue_fifo_entry_t new_entry;
  issue_fifo_entry_t head;
  logic [31:0]       shifted;
  logic [31:0]       load_result;

  // AMOs always operate on a full word regardless of the fn3 they carry;
  // otherwise the low two fn3 bits give the access width (unused codes are
  // treated as words).
  always_comb begin
    acc_size = SIZE_WORD;
    if (!req_amo_rmw) begin
      case (req_fn3[1:0])
        2'd0:    acc_size = SIZE_BYTE;
        2'd1:    acc_size = SIZE_HALF;
        default: acc_size = SIZE_WORD;
      endcase
    end
  end

  assign misaligned = ((acc_size == SIZE_HALF) && req_addr[0]) ||
                      ((acc_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

  // The FIFO-full test looks at the occupancy before any same-cycle pop, so
  // a returning data_valid never opens a combinational path into req_ready.
  assign req_ready    = !rst && unit.ready && !fifo_full;
  assign accept       = req_valid && req_ready;
  assign issue        = accept && !misaligned;
  assign expects_data = !req_store || req_amo_rmw;

  // Byte enables and lane-replicated write data. Plain loads drive no byte
  // enables; AMOs need all four lanes for the write-back.
  always_comb begin
    be_mask    = 4'b0000;
    store_data = req_data;
    case (acc_size)
      SIZE_BYTE: begin
        be_mask    = 4'b0001 << req_addr[1:0];
        store_data = {4{req_data[7:0]}};
      end
      SIZE_HALF: begin
        be_mask    = 4'b0011 << req_addr[1:0];
        store_data = {2{req_data[15:0]}};
      end
      default: begin
        be_mask    = 4'b1111;
        store_data = req_data;
      end
    endcase
    if (!req_store && !req_amo_rmw)
      be_mask = 4'b0000;
  end

  assign unit.new_request = issue;
  assign unit.addr        = req_addr;
  assign unit.re          = !req_store || req_amo_rmw;
  assign unit.we          = req_store && !req_amo_rmw;
  assign unit.be          = be_mask;
  assign unit.data_in     = store_data;
  assign amo_is_rmw       = issue && req_amo_rmw;

  // Remember enough about every data-returning request to align and extend
  // its result when the sub-unit answers (responses arrive in issue order).
  always_comb begin
    new_entry.id       = req_id;
    new_entry.byte_off = req_addr[1:0];
    new_entry.fn3      = req_amo_rmw ? FN3_LW : req_fn3;
  end

  assign fifo_push = issue && expects_data;
  assign fifo_pop  = unit.data_valid && !fifo_empty;

  cva5_fifo #(
    .DATA_W ($bits(issue_fifo_entry_t)),
    .DEPTH  (MAX_OUTSTANDING)
  ) outstanding_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .data_in  (new_entry),
    .data_out (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Move the addressed lane down to bit 0, then sign- or zero-extend. For
  // halfwords the offset is always 0 or 2, so the same byte shift works.
  always_comb begin
    shifted     = unit.data_out >> {head.byte_off, 3'b000};
    load_result = unit.data_out;
    case (head.fn3)
      FN3_LB:  load_result = {{24{shifted[7]}}, shifted[7:0]};
      FN3_LBU: load_result = {24'h000000, shifted[7:0]};
      FN3_LH:  load_result = {{16{shifted[15]}}, shifted[15:0]};
      FN3_LHU: load_result = {16'h0000, shifted[15:0]};
      default: load_result = unit.data_out;
    endcase
  end

  // Registered response, rejection and protocol-error outputs. A data_valid
  // with nothing outstanding is a sub-unit protocol violation: it is latched
  // in proto_err and produces no response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      err_valid <= 1'b0;
      err_id    <= '0;
      proto_err <= 1'b0;
    end else begin
      rsp_valid <= fifo_pop;
      if (fifo_pop) begin
        rsp_data <= load_result;
        rsp_id   <= head.id;
      end
      err_valid <= accept && misaligned;
      if (accept && misaligned)
        err_id <= req_id;
      if (unit.data_valid && fifo_empty)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sub_unit_request_issuer.sv
// ---------------------------------------------------------------------------
// tb_sub_unit_request_issuer
//   Directed self-checking bench for sub_unit_request_issuer. The bench plays
//   the memory sub-unit by driving ready/data_out/data_valid directly.
// ---------------------------------------------------------------------------
module tb_sub_unit_request_issuer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_store;
  logic [2:0]  req_fn3;
  logic [31:0] req_data;
  logic        req_amo_rmw;
  logic [2:0]  req_id;
  logic        amo_is_rmw;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_id;
  logic        err_valid;
  logic [2:0]  err_id;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;

  memory_sub_unit_interface unit_if ();

  sub_unit_request_issuer #(
    .MAX_OUTSTANDING (4),
    .ID_W            (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_store   (req_store),
    .req_fn3     (req_fn3),
    .req_data    (req_data),
    .req_amo_rmw (req_amo_rmw),
    .req_id      (req_id),
    .unit        (unit_if),
    .amo_is_rmw  (amo_is_rmw),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .err_valid   (err_valid),
    .err_id      (err_id),
    .proto_err   (proto_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so outputs are stable.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                               input logic store, input logic [2:0] fn3,
                               input logic [31:0] data, input logic amo,
                               input logic [2:0] id);
    req_valid   = valid;
    req_addr    = addr;
    req_store   = store;
    req_fn3     = fn3;
    req_data    = data;
    req_amo_rmw = amo;
    req_id      = id;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One sub-unit return: present data_out with data_valid for one cycle.
  task automatic returnData(input logic [31:0] data);
    unit_if.data_valid = 1'b1;
    unit_if.data_out   = data;
    tick();
    unit_if.data_valid = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    unit_if.ready      = 1'b1;
    unit_if.data_valid = 1'b0;
    unit_if.data_out   = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    tick();
    tick();

    // Reset state
    checkOutput("ready_in_reset", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_err_valid", {31'b0, err_valid}, 32'd0);
    checkOutput("rst_proto_err", {31'b0, proto_err}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    checkOutput("rst_rsp_id", {29'b0, rsp_id}, 32'd0);
    checkOutput("rst_err_id", {29'b0, err_id}, 32'd0);
    rst = 1'b0;
    #1;

    // LW 0x100
    applyStimulus(1'b1, 32'h100, 1'b0, 3'd2, 32'h0, 1'b0, 3'd1);
    #1;
    checkOutput("lw_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("lw_new_request", {31'b0, unit_if.new_request}, 32'd1);
    checkOutput("lw_addr", unit_if.addr, 32'h100);
    checkOutput("lw_re", {31'b0, unit_if.re}, 32'd1);
    checkOutput("lw_we", {31'b0, unit_if.we}, 32'd0);
    checkOutput("lw_be", {28'b0, unit_if.be}, 32'h0);
    tick();
    req_valid = 1'b0;
    returnData(32'hDEADBEEF);
    checkOutput("lw_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("lw_rsp_data", rsp_data, 32'hDEADBEEF);
    checkOutput("lw_rsp_id", {29'b0, rsp_id}, 32'd1);
    tick();
    checkOutput("lw_rsp_pulse", {31'b0, rsp_valid}, 32'd0);

    // LB / LBU 0x103
    applyStimulus(1'b1, 32'h103, 1'b0, 3'd0, 32'h0, 1'b0, 3'd2);
    tick();
    req_valid = 1'b0;
    returnData(32'h80AABBCC);
    checkOutput("lb_rsp_data", rsp_data, 32'hFFFFFF80);
    checkOutput("lb_rsp_id", {29'b0, rsp_id}, 32'd2);
    applyStimulus(1'b1, 32'h103, 1'b0, 3'd4, 32'h0, 1'b0, 3'd3);
    tick();
    req_valid = 1'b0;
    returnData(32'h80AABBCC);
    checkOutput("lbu_rsp_data", rsp_data, 32'h00000080);
    checkOutput("lbu_rsp_id", {29'b0, rsp_id}, 32'd3);

    // SH 0x102 and SB 0x101
    applyStimulus(1'b1, 32'h102, 1'b1, 3'd1, 32'h1234ABCD, 1'b0, 3'd4);
    #1;
    checkOutput("sh_new_request", {31'b0, unit_if.new_request}, 32'd1);
    checkOutput("sh_be", {28'b0, unit_if.be}, 32'hC);
    checkOutput("sh_data_in", unit_if.data_in, 32'hABCDABCD);
    checkOutput("sh_we", {31'b0, unit_if.we}, 32'd1);
    checkOutput("sh_re", {31'b0, unit_if.re}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h101, 1'b1, 3'd0, 32'h0000005A, 1'b0, 3'd4);
    #1;
    checkOutput("sb_be", {28'b0, unit_if.be}, 32'h2);
    checkOutput("sb_data_in", unit_if.data_in, 32'h5A5A5A5A);
    tick();
    req_valid = 1'b0;
    tick();
    checkOutput("store_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Misaligned LW 0x101
    applyStimulus(1'b1, 32'h101, 1'b0, 3'd2, 32'h0, 1'b0, 3'd5);
    #1;
    checkOutput("mis_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("mis_new_request", {31'b0, unit_if.new_request}, 32'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("mis_err_valid", {31'b0, err_valid}, 32'd1);
    checkOutput("mis_err_id", {29'b0, err_id}, 32'd5);
    tick();
    checkOutput("mis_err_pulse", {31'b0, err_valid}, 32'd0);
    checkOutput("mis_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Fill four outstanding loads, then drain in order
    applyStimulus(1'b1, 32'h200, 1'b0, 3'd2, 32'h0, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b1, 32'h202, 1'b0, 3'd1, 32'h0, 1'b0, 3'd1);
    tick();
    applyStimulus(1'b1, 32'h202, 1'b0, 3'd5, 32'h0, 1'b0, 3'd2);
    tick();
    applyStimulus(1'b1, 32'h201, 1'b0, 3'd0, 32'h0, 1'b0, 3'd3);
    tick();
    applyStimulus(1'b1, 32'h300, 1'b0, 3'd2, 32'h0, 1'b0, 3'd6);
    #1;
    checkOutput("full_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("full_new_request", {31'b0, unit_if.new_request}, 32'd0);
    req_valid = 1'b0;
    unit_if.data_valid = 1'b1;
    unit_if.data_out   = 32'h11223344;
    #1;
    checkOutput("full_ready_prepop", {31'b0, req_ready}, 32'd0);
    tick();
    checkOutput("drain0_data", rsp_data, 32'h11223344);
    checkOutput("drain0_id", {29'b0, rsp_id}, 32'd0);
    checkOutput("drain_ready_after_pop", {31'b0, req_ready}, 32'd1);
    unit_if.data_out = 32'h80017FFF;
    tick();
    checkOutput("drain1_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("drain1_data", rsp_data, 32'hFFFF8001);
    checkOutput("drain1_id", {29'b0, rsp_id}, 32'd1);
    tick();
    checkOutput("drain2_data", rsp_data, 32'h00008001);
    checkOutput("drain2_id", {29'b0, rsp_id}, 32'd2);
    unit_if.data_out = 32'h0000FF00;
    tick();
    checkOutput("drain3_data", rsp_data, 32'hFFFFFFFF);
    checkOutput("drain3_id", {29'b0, rsp_id}, 32'd3);
    unit_if.data_valid = 1'b0;
    tick();
    checkOutput("drain_done", {31'b0, rsp_valid}, 32'd0);
    checkOutput("drain_no_proto", {31'b0, proto_err}, 32'd0);

    // Push and pop in the same cycle
    applyStimulus(1'b1, 32'h400, 1'b0, 3'd2, 32'h0, 1'b0, 3'd1);
    tick();
    applyStimulus(1'b1, 32'h402, 1'b0, 3'd4, 32'h0, 1'b0, 3'd2);
    returnData(32'hCAFEF00D);
    req_valid = 1'b0;
    checkOutput("pp_rsp0_data", rsp_data, 32'hCAFEF00D);
    checkOutput("pp_rsp0_id", {29'b0, rsp_id}, 32'd1);
    returnData(32'h00AB0000);
    checkOutput("pp_rsp1_data", rsp_data, 32'h000000AB);
    checkOutput("pp_rsp1_id", {29'b0, rsp_id}, 32'd2);
    checkOutput("pp_no_proto", {31'b0, proto_err}, 32'd0);

    // Sub-unit stall blocks acceptance
    unit_if.ready = 1'b0;
    applyStimulus(1'b1, 32'h600, 1'b0, 3'd2, 32'h0, 1'b0, 3'd4);
    #1;
    checkOutput("stall_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("stall_new_request", {31'b0, unit_if.new_request}, 32'd0);
    tick();
    req_valid     = 1'b0;
    unit_if.ready = 1'b1;

    // Reset, then an unexpected data_valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    returnData(32'h12345678);
    checkOutput("proto_set", {31'b0, proto_err}, 32'd1);
    checkOutput("proto_no_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    checkOutput("proto_sticky", {31'b0, proto_err}, 32'd1);

    // AMO add: forced word access, byte fn3 ignored
    applyStimulus(1'b1, 32'h500, 1'b0, 3'd0, 32'h00000007, 1'b1, 3'd7);
    #1;
    checkOutput("amo_is_rmw", {31'b0, amo_is_rmw}, 32'd1);
    checkOutput("amo_new_request", {31'b0, unit_if.new_request}, 32'd1);
    checkOutput("amo_be", {28'b0, unit_if.be}, 32'hF);
    checkOutput("amo_re", {31'b0, unit_if.re}, 32'd1);
    checkOutput("amo_we", {31'b0, unit_if.we}, 32'd0);
    checkOutput("amo_data_in", unit_if.data_in, 32'h00000007);
    tick();
    req_valid = 1'b0;
    returnData(32'h12345680);
    checkOutput("amo_rsp_data", rsp_data, 32'h12345680);
    checkOutput("amo_rsp_id", {29'b0, rsp_id}, 32'd7);

    // Misaligned AMO
    applyStimulus(1'b1, 32'h502, 1'b0, 3'd2, 32'h0, 1'b1, 3'd6);
    #1;
    checkOutput("amo_mis_new_request", {31'b0, unit_if.new_request}, 32'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("amo_mis_err_valid", {31'b0, err_valid}, 32'd1);
    checkOutput("amo_mis_err_id", {29'b0, err_id}, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
